// File: rtl/video_timing_gen_if.sv
// Bundle of run-enable, timing-configuration handshake and video outputs for
// video_timing_gen.
//   master : drives en and the cfg_* offer, observes cfg_ready/cfg_err and video
//   slave  : the timing generator itself
interface video_timing_gen_if #(
  parameter int unsigned CW = 12
) ();
  logic          en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [4*CW-1:0] cfg_h;
  logic [4*CW-1:0] cfg_v;
  logic [1:0]    cfg_pol;
  logic          cfg_err;
  logic          hs;
  logic          vs;
  logic          de;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;

  modport master (
    output en, cfg_valid, cfg_h, cfg_v, cfg_pol,
    input  cfg_ready, cfg_err, hs, vs, de, x, y, line_start, frame_start
  );

  modport slave (
    input  en, cfg_valid, cfg_h, cfg_v, cfg_pol,
    output cfg_ready, cfg_err, hs, vs, de, x, y, line_start, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator.
// A line is ordered sync, back porch, active, front porch; frames are ordered the
// same way in lines. New timing is offered through a one-deep shadow register and
// only takes effect at a frame boundary (or immediately while en is low).
// Ports:
//   clk  pixel clock
//   rst  asynchronous, active-high reset
//   bus  video_timing_gen_if.slave: en, cfg_valid/cfg_ready/cfg_h/cfg_v/cfg_pol,
//        cfg_err, hs, vs, de, x, y, line_start, frame_start
// All video outputs are registered and lag the counters by one cycle.
module video_timing_gen #(
  parameter int unsigned CW       = 12,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input logic               clk,
  input logic               rst,
  video_timing_gen_if.slave bus
);
  localparam int unsigned TW = CW + 2;

  // Working timing set
  logic [CW-1:0] h_act_q, h_fp_q, h_sync_q, h_bp_q;
  logic [CW-1:0] v_act_q, v_fp_q, v_sync_q, v_bp_q;
  logic          hs_pol_q, vs_pol_q;

  // Shadow set waiting for a frame boundary
  logic [4*CW-1:0] sh_h_q, sh_v_q;
  logic [1:0]      sh_pol_q;
  logic            pending_q;
  logic            cfg_err_q;

  logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic          apply;

  // Output registers
  logic          hs_q, vs_q, de_q, ls_q, fs_q;
  logic [CW-1:0] x_q, y_q;

  // Config acceptance
  logic cfg_ok, cfg_take, cfg_rej;

  assign cfg_ok = (bus.cfg_h[4*CW-1:3*CW] != '0) && (bus.cfg_h[3*CW-1:2*CW] != '0) &&
                  (bus.cfg_h[2*CW-1:CW]   != '0) && (bus.cfg_h[CW-1:0]      != '0) &&
                  (bus.cfg_v[4*CW-1:3*CW] != '0) && (bus.cfg_v[3*CW-1:2*CW] != '0) &&
                  (bus.cfg_v[2*CW-1:CW]   != '0) && (bus.cfg_v[CW-1:0]      != '0);
  assign cfg_take = bus.cfg_valid && !pending_q && cfg_ok;
  assign cfg_rej  = bus.cfg_valid && !pending_q && !cfg_ok;

  // Totals and region bounds, widened so sums cannot wrap
  logic [TW-1:0] h_total, v_total, h_act_start, h_act_end, v_act_start, v_act_end;
  logic [TW-1:0] hc, vc;
  logic          h_last, v_last;

  assign h_total     = {2'b00, h_act_q} + {2'b00, h_fp_q} + {2'b00, h_sync_q} + {2'b00, h_bp_q};
  assign v_total     = {2'b00, v_act_q} + {2'b00, v_fp_q} + {2'b00, v_sync_q} + {2'b00, v_bp_q};
  assign h_act_start = {2'b00, h_sync_q} + {2'b00, h_bp_q};
  assign v_act_start = {2'b00, v_sync_q} + {2'b00, v_bp_q};
  assign h_act_end   = h_act_start + {2'b00, h_act_q};
  assign v_act_end   = v_act_start + {2'b00, v_act_q};
  assign hc          = {2'b00, h_cnt_q};
  assign vc          = {2'b00, v_cnt_q};
  assign h_last      = (hc == h_total - TW'(1));
  assign v_last      = (vc == v_total - TW'(1));

  // Counter next state; apply marks the cycle the shadow becomes the working set
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    apply   = 1'b0;
    if (!bus.en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
      apply   = pending_q;
    end else if (h_last) begin
      h_cnt_d = '0;
      if (v_last) begin
        v_cnt_d = '0;
        apply   = pending_q;
      end else begin
        v_cnt_d = v_cnt_q + CW'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // apply needs pending_q and cfg_take needs !pending_q, so they never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_act_q   <= CW'(H_ACTIVE);
      h_fp_q    <= CW'(H_FP);
      h_sync_q  <= CW'(H_SYNC);
      h_bp_q    <= CW'(H_BP);
      v_act_q   <= CW'(V_ACTIVE);
      v_fp_q    <= CW'(V_FP);
      v_sync_q  <= CW'(V_SYNC);
      v_bp_q    <= CW'(V_BP);
      hs_pol_q  <= HS_POL;
      vs_pol_q  <= VS_POL;
      sh_h_q    <= '0;
      sh_v_q    <= '0;
      sh_pol_q  <= '0;
      pending_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_rej;
      if (apply) begin
        h_act_q   <= sh_h_q[4*CW-1:3*CW];
        h_fp_q    <= sh_h_q[3*CW-1:2*CW];
        h_sync_q  <= sh_h_q[2*CW-1:CW];
        h_bp_q    <= sh_h_q[CW-1:0];
        v_act_q   <= sh_v_q[4*CW-1:3*CW];
        v_fp_q    <= sh_v_q[3*CW-1:2*CW];
        v_sync_q  <= sh_v_q[2*CW-1:CW];
        v_bp_q    <= sh_v_q[CW-1:0];
        vs_pol_q  <= sh_pol_q[1];
        hs_pol_q  <= sh_pol_q[0];
        pending_q <= 1'b0;
      end else if (cfg_take) begin
        sh_h_q    <= bus.cfg_h;
        sh_v_q    <= bus.cfg_v;
        sh_pol_q  <= bus.cfg_pol;
        pending_q <= 1'b1;
      end
    end
  end

  // Output decode from the current counters
  logic          in_hsync, in_vsync, de_d, ls_d, fs_d, hs_d, vs_d;
  logic [CW-1:0] x_d, y_d;

  always_comb begin
    in_hsync = (hc < {2'b00, h_sync_q});
    in_vsync = (vc < {2'b00, v_sync_q});
    de_d     = bus.en && (hc >= h_act_start) && (hc < h_act_end) &&
               (vc >= v_act_start) && (vc < v_act_end);
    hs_d     = (bus.en && in_hsync) ? hs_pol_q : ~hs_pol_q;
    vs_d     = (bus.en && in_vsync) ? vs_pol_q : ~vs_pol_q;
    x_d      = '0;
    y_d      = '0;
    if (de_d) begin
      x_d = h_cnt_q - (h_sync_q + h_bp_q);
      y_d = v_cnt_q - (v_sync_q + v_bp_q);
    end
    ls_d = de_d && (x_d == '0);
    fs_d = ls_d && (y_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign bus.cfg_ready   = ~pending_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.hs          = hs_q;
  assign bus.vs          = vs_q;
  assign bus.de          = de_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen. Uses a small raster so whole frames
// fit in a short run:
//   reset set : H 10/2/3/4 (total 19), V 6/1/2/3 (total 12), negative syncs
//   new set   : H 12/1/5/2 (total 20), V 7/2/1/3 (total 13), positive syncs
// cyc counts clock edges since the last restart; after edge k the outputs show
// counter position k-1.
module tb_video_timing_gen;
  localparam int unsigned CW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  video_timing_gen_if #(.CW(CW)) bus ();

  video_timing_gen #(
    .CW(CW), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Running statistics
  int cyc, hs_lo, hs_hi, vs_lo, vs_hi, de_n, ls_n, fs_n, bad_vs, xy_bad;
  int last_x, last_y, fs_x, fs_y;
  logic first_hs, first_vs, prev_hs, prev_vs;
  int fs_q[$];

  task automatic clear_window();
    hs_lo = 0; hs_hi = 0; vs_lo = 0; vs_hi = 0;
    de_n = 0; ls_n = 0; fs_n = 0; bad_vs = 0; xy_bad = 0;
    last_x = -1; last_y = -1; fs_x = -1; fs_y = -1;
    prev_hs = bus.hs; prev_vs = bus.vs;
  endtask

  task automatic clear_stats();
    clear_window();
    cyc = 0;
    fs_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == 1) begin
      first_hs = bus.hs;
      first_vs = bus.vs;
    end
    if (bus.hs) hs_hi++; else hs_lo++;
    if (bus.vs) vs_hi++; else vs_lo++;
    if (bus.de) begin
      de_n++;
      last_x = int'(bus.x);
      last_y = int'(bus.y);
    end else if (bus.x != '0 || bus.y != '0) begin
      xy_bad++;
    end
    if (bus.line_start) ls_n++;
    if (bus.frame_start) begin
      fs_n++;
      fs_q.push_back(cyc);
      fs_x = int'(bus.x);
      fs_y = int'(bus.y);
    end
    // vs may only move on the cycle hs moves (line start)
    if (bus.vs != prev_vs && bus.hs == prev_hs) bad_vs++;
    prev_hs = bus.hs;
    prev_vs = bus.vs;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ready"}, 32'(bus.cfg_ready), 1);
    check_eq({tag, "_err"}, 32'(bus.cfg_err), 0);
    check_eq({tag, "_de"}, 32'(bus.de), 0);
    check_eq({tag, "_x"}, 32'(bus.x), 0);
    check_eq({tag, "_y"}, 32'(bus.y), 0);
    check_eq({tag, "_hs"}, 32'(bus.hs), 1);
    check_eq({tag, "_vs"}, 32'(bus.vs), 1);
    check_eq({tag, "_ls"}, 32'(bus.line_start), 0);
    check_eq({tag, "_fs"}, 32'(bus.frame_start), 0);
  endtask

  // One full reset-set frame from counter 0: fs at edge 5*19+7+1 = 103
  task automatic check_first_frame(input string tag);
    run(228);
    check_eq({tag, "_hs_first"}, 32'(first_hs), 0);
    check_eq({tag, "_vs_first"}, 32'(first_vs), 0);
    check_eq({tag, "_hs_lo"}, hs_lo, 36);
    check_eq({tag, "_vs_lo"}, vs_lo, 38);
    check_eq({tag, "_de_n"}, de_n, 60);
    check_eq({tag, "_ls_n"}, ls_n, 6);
    check_eq({tag, "_fs_n"}, fs_n, 1);
    check_eq({tag, "_fs_cyc"}, (fs_q.size() > 0) ? fs_q[0] : -1, 103);
    check_eq({tag, "_fs_x"}, fs_x, 0);
    check_eq({tag, "_fs_y"}, fs_y, 0);
    check_eq({tag, "_last_x"}, last_x, 9);
    check_eq({tag, "_last_y"}, last_y, 5);
    check_eq({tag, "_vs_align"}, bad_vs, 0);
    check_eq({tag, "_xy_idle"}, xy_bad, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_h = '0;
    bus.cfg_v = '0;
    bus.cfg_pol = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    clear_stats();
    run(3);
    check_eq("idle_de", 32'(bus.de), 0);
    check_eq("idle_hs", 32'(bus.hs), 1);

    // First frame from en rising
    bus.en = 1'b1;
    clear_stats();
    check_first_frame("f1");

    // Pause mid-line for 1000 cycles
    run(10);
    bus.en = 1'b0;
    step();
    check_eq("pause_de", 32'(bus.de), 0);
    check_eq("pause_hs", 32'(bus.hs), 1);
    check_eq("pause_vs", 32'(bus.vs), 1);
    check_eq("pause_x", 32'(bus.x), 0);
    run(999);
    check_eq("pause_end_de", 32'(bus.de), 0);
    check_eq("pause_end_hs", 32'(bus.hs), 1);
    check_eq("pause_end_vs", 32'(bus.vs), 1);
    check_eq("pause_end_ls", 32'(bus.line_start), 0);
    bus.en = 1'b1;
    clear_stats();
    check_first_frame("restart");

    // Reconfigure mid-frame 2; frame 3 (counter 456..715) uses the new set
    clear_window();
    run(50);
    bus.cfg_h = {12'd12, 12'd1, 12'd5, 12'd2};
    bus.cfg_v = {12'd7, 12'd2, 12'd1, 12'd3};
    bus.cfg_pol = 2'b11;
    bus.cfg_valid = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    check_eq("cfg_ready_drop", 32'(bus.cfg_ready), 0);
    check_eq("cfg_no_err", 32'(bus.cfg_err), 0);
    run(176);
    check_eq("cfg_ready_held", 32'(bus.cfg_ready), 0);
    step();
    check_eq("cfg_ready_back", 32'(bus.cfg_ready), 1);
    check_eq("f2_de_n", de_n, 60);
    check_eq("f2_hs_lo", hs_lo, 36);
    check_eq("f2_ls_n", ls_n, 6);
    check_eq("f2_fs_cyc", fs_q[$], 331);

    clear_window();
    run(260);
    check_eq("f3_hs_hi", hs_hi, 65);
    check_eq("f3_vs_hi", vs_hi, 20);
    check_eq("f3_de_n", de_n, 84);
    check_eq("f3_ls_n", ls_n, 7);
    check_eq("f3_fs_n", fs_n, 1);
    check_eq("f3_fs_cyc", fs_q[$], 544);
    check_eq("f2_f3_gap", fs_q[$] - fs_q[$-1], 213);
    check_eq("f3_last_x", last_x, 11);
    check_eq("f3_last_y", last_y, 6);
    check_eq("f3_vs_align", bad_vs, 0);

    // Rejected offer: zero horizontal sync
    clear_window();
    bus.cfg_h = {12'd10, 12'd2, 12'd0, 12'd4};
    bus.cfg_v = {12'd6, 12'd1, 12'd2, 12'd3};
    bus.cfg_pol = 2'b00;
    bus.cfg_valid = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    check_eq("rej_err", 32'(bus.cfg_err), 1);
    check_eq("rej_ready", 32'(bus.cfg_ready), 1);
    step();
    check_eq("rej_err_pulse", 32'(bus.cfg_err), 0);
    run(258);
    check_eq("f4_de_n", de_n, 84);
    check_eq("f4_hs_hi", hs_hi, 65);
    check_eq("f4_fs_cyc", fs_q[$], 804);
    check_eq("f3_f4_gap", fs_q[$] - fs_q[$-1], 260);
    check_eq("f4_ready", 32'(bus.cfg_ready), 1);

    // Reset mid-frame with a pending shadow
    bus.cfg_h = {12'd4, 12'd1, 12'd1, 12'd1};
    bus.cfg_v = {12'd4, 12'd1, 12'd1, 12'd1};
    bus.cfg_pol = 2'b11;
    bus.cfg_valid = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    check_eq("pend_ready", 32'(bus.cfg_ready), 0);
    run(5);
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stats();
    check_first_frame("post_rst");
    clear_window();
    run(228);
    check_eq("post_rst_f2_de", de_n, 60);
    check_eq("post_rst_f2_hs", hs_lo, 36);
    check_eq("post_rst_f2_fs", fs_q[$], 331);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter CW, default 12: width of every counter, coordinate and timing field.
REQ-002 Parameter H_ACTIVE, default 640: reset-time horizontal active pixels.
REQ-003 Parameter H_FP, default 16: reset-time horizontal front porch.
REQ-004 Parameter H_SYNC, default 96: reset-time horizontal sync width.
REQ-005 Parameter H_BP, default 48: reset-time horizontal back porch.
REQ-006 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: reset-time vertical timing in lines.
REQ-007 Parameters HS_POL/VS_POL, default 0/0: reset-time active sync level.
REQ-008 clk  in  1  pixel clock.
REQ-009 rst  in  1  reset, asynchronous, active-high.
REQ-010 en  in  1  timing run enable.
REQ-011 cfg_valid  in  1  new timing offered.
REQ-012 cfg_ready  out  1  shadow register free.
REQ-013 cfg_h  in  4*CW  {active,fp,sync,bp}, active in MSBs.
REQ-014 cfg_v  in  4*CW  {active,fp,sync,bp}, same packing, in lines.
REQ-015 cfg_pol  in  2  {vs_pol,hs_pol}.
REQ-016 cfg_err  out  1  one-cycle pulse: offered config rejected.
REQ-017 hs, vs  out  1 each  sync outputs.
REQ-018 de  out  1  active video.
REQ-019 x, y  out  CW each  active pixel coordinates.
REQ-020 line_start, frame_start  out  1 each  one-cycle pulses.

Function
REQ-021 Working timing set (h/v fields, polarities) SHALL drive all counting; H_TOTAL = active+fp+sync+bp, same for V_TOTAL, computed in CW+2 bits.
REQ-022 Line order: sync [0,SYNC), back porch, active [SYNC+BP, SYNC+BP+ACTIVE), front porch; vertical same order, in lines.
REQ-023 h_cnt SHALL count 0..H_TOTAL-1 then wrap to 0; v_cnt SHALL advance when h_cnt wraps and wrap to 0 after V_TOTAL-1.
REQ-024 All outputs SHALL be registered, reflecting counter state of the previous cycle (latency 1).
REQ-025 hs = hs_pol while h_cnt in sync region, else ~hs_pol; vs likewise from v_cnt and vs_pol; vs edges SHALL coincide with hs leading edge (h_cnt==0).
REQ-026 de = 1 iff h_cnt and v_cnt both in active region.
REQ-027 x = h_cnt-(H_SYNC+H_BP), y = v_cnt-(V_SYNC+V_BP) while de=1; x=y=0 otherwise.
REQ-028 line_start SHALL pulse with every de cycle where x=0; frame_start SHALL pulse only where x=0 and y=0.
REQ-029 cfg_ready = ~pending; cfg_valid&&cfg_ready with all eight fields nonzero SHALL load shadow and set pending.
REQ-030 Offer with any zero field SHALL be rejected: shadow untouched, pending stays 0, cfg_err pulses next cycle.
REQ-031 Pending shadow SHALL be copied to working set on the cycle h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1 (frame end); pending clears same edge; counters wrap to 0.
REQ-032 en=0: counters held at 0, de/line_start/frame_start 0, x=y=0, hs/vs at inactive level; pending shadow SHALL apply on the next cycle.
REQ-033 en rising: counting resumes from h_cnt=v_cnt=0; first sync output appears one cycle later.
REQ-034 A working-set change SHALL never shorten or truncate a frame in progress.

Reset
REQ-035 rst SHALL load working set from parameters, clear counters and pending, force cfg_ready=1, cfg_err=0, de=0, x=y=0, pulses 0, hs=~HS_POL, vs=~VS_POL.
REQ-036 rst asserted mid-frame SHALL abort the frame and discard any pending shadow.

Verification
REQ-037 Defaults, en=1 after reset: hs low 96 clocks per 800-clock line; vs low 2 lines per 525-line frame; 640x480 de cycles per frame.
REQ-038 First frame: frame_start at output cycle (2+33)*800+96+48+1, with x=0,y=0; final de cycle has x=639,y=479.
REQ-039 Offer cfg_h={800,40,128,88}, cfg_v={600,1,4,23}, cfg_pol=2'b11 mid-frame: cfg_ready drops, current frame stays 800x525, next frame 1056x628 with positive syncs, cfg_ready returns to 1.
REQ-040 Offer with cfg_h sync field 0 -> cfg_err single pulse, cfg_ready stays 1, timing unchanged.
REQ-041 en=0 for 1000 cycles mid-line -> de=0, hs=vs=1 (defaults); en=1 -> hs low starts one cycle later, line/frame restart at 0.
REQ-042 rst pulse mid-frame with config pending -> outputs at reset values; subsequent frames use 640x480 defaults.
